p405s_apulddataasm: RTL

Receive-side counterpart of the PCL storage sequencer for APU/FCM load operations. It accepts the per-cycle 32-bit load words the core returns and byte-merges them into a 128-bit quadword buffer. Word count and starting lane come from the word-count and QW-lane enables issued at EXE. The finished quadword is presented to the APU with a valid/ack handshake.

---
 rtl/p405s_apulddataasm.sv | 236 +++++++++++++++++++++++
 1 files changed

// File: rtl/p405s_apulddataasm.sv
// p405s_apulddataasm: APU/FCM load-data assembler.
// Collects the 32-bit big-endian load words returned by the core, byte-merges
// them into a quadword buffer starting at the lane chosen at EXE, and hands
// the finished quadword to the APU under a valid/ack handshake.
module p405s_apulddataasm #(
  parameter int QW_WORDS = 4
) (
  input  logic                   CB,
  input  logic                   resetCore,
  input  logic                   PCL_apuLdStart,
  input  logic [0:1]             PCL_apuExeWdCnt,
  input  logic [0:3]             PCL_exeEaQwEn,
  input  logic                   IFB_exeFlush,
  input  logic                   DCU_ldDataVal,
  input  logic [0:31]            DCU_ldData,
  input  logic [0:3]             PCL_dcuByteEn,
  input  logic                   APU_ldAck,
  output logic [0:QW_WORDS*32-1] APU_ldData,
  output logic                   APU_ldDataVal,
  output logic [0:QW_WORDS*4-1]  APU_ldByteEn,
  output logic                   asmBusy,
  output logic                   asmErr
);

  localparam int QW_BITS  = QW_WORDS * 32;
  localparam int QW_BYTES = QW_WORDS * 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_HOLD    = 2'd2
  } state_t;

  // True when exactly one lane-enable bit is set.
  function automatic logic onehot4(input logic [0:3] v);
    logic [2:0] cnt;
    cnt = 3'd0;
    for (int i = 0; i < 4; i++) begin
      cnt = cnt + {2'b00, v[i]};
    end
    return (cnt == 3'd1);
  endfunction

  // Index of the set bit in a one-hot lane enable (bit 0 = lane 0).
  function automatic logic [1:0] lane_index(input logic [0:3] v);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (v[i]) begin
        idx = 2'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

  // Overlay the enabled bytes of one load word onto the given lane.
  function automatic logic [0:QW_BITS-1] merge_data(
    input logic [0:QW_BITS-1] qw,
    input logic [1:0]         lane,
    input logic [0:31]        word,
    input logic [0:3]         be
  );
    logic [0:QW_BITS-1] res;
    res = qw;
    for (int k = 0; k < 4; k++) begin
      if (be[k]) begin
        res[int'(lane)*32 + k*8 +: 8] = word[k*8 +: 8];
      end else begin
        res[int'(lane)*32 + k*8 +: 8] = qw[int'(lane)*32 + k*8 +: 8];
      end
    end
    return res;
  endfunction

  // Accumulate the byte enables of one load word into the lane's slots.
  function automatic logic [0:QW_BYTES-1] merge_ben(
    input logic [0:QW_BYTES-1] ben,
    input logic [1:0]          lane,
    input logic [0:3]          be
  );
    logic [0:QW_BYTES-1] res;
    res = ben;
    for (int k = 0; k < 4; k++) begin
      res[int'(lane)*4 + k] = ben[int'(lane)*4 + k] | be[k];
    end
    return res;
  endfunction

  state_t              state_q, state_d;
  logic [0:QW_BITS-1]  data_q, data_d;
  logic [0:QW_BYTES-1] ben_q, ben_d;
  logic                val_q, val_d;
  logic                busy_q, busy_d;
  logic                err_q, err_d;
  logic [2:0]          rem_q, rem_d;
  logic [1:0]          lane_q, lane_d;

  logic                start_legal_s;
  logic [1:0]          start_lane_s;
  logic [2:0]          start_rem_s;
  logic [0:QW_BITS-1]  merged_data_s;
  logic [0:QW_BYTES-1] merged_ben_s;

  // Decode the start request: lane, word count and whether it fits without wrap.
  always_comb begin
    start_lane_s  = lane_index(PCL_exeEaQwEn);
    start_rem_s   = {1'b0, PCL_apuExeWdCnt} + 3'd1;
    start_legal_s = onehot4(PCL_exeEaQwEn) &&
                    (({1'b0, start_lane_s} + {1'b0, PCL_apuExeWdCnt}) <= 3'd3);
    merged_data_s = merge_data(data_q, lane_q, DCU_ldData, PCL_dcuByteEn);
    merged_ben_s  = merge_ben(ben_q, lane_q, PCL_dcuByteEn);
  end

  // Next-state, buffer and error computation for the assembler.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    ben_d   = ben_q;
    rem_d   = rem_q;
    lane_d  = lane_q;
    err_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Load data arriving here is stray and dropped; a flush kills the start.
        if (PCL_apuLdStart && !IFB_exeFlush) begin
          if (start_legal_s) begin
            state_d = ST_COLLECT;
            rem_d   = start_rem_s;
            lane_d  = start_lane_s;
            data_d  = {QW_BITS{1'b0}};
            ben_d   = {QW_BYTES{1'b0}};
          end else begin
            err_d   = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_COLLECT: begin
        if (PCL_apuLdStart) begin
          err_d = 1'b1;
        end else begin
          err_d = 1'b0;
        end
        if (IFB_exeFlush) begin
          // Abort wins even over a final data beat.
          state_d = ST_IDLE;
          ben_d   = {QW_BYTES{1'b0}};
        end else if (DCU_ldDataVal) begin
          data_d = merged_data_s;
          ben_d  = merged_ben_s;
          lane_d = lane_q + 2'd1;
          rem_d  = rem_q - 3'd1;
          if (rem_q == 3'd1) begin
            state_d = ST_HOLD;
          end else begin
            state_d = ST_COLLECT;
          end
        end else begin
          state_d = ST_COLLECT;
        end
      end

      ST_HOLD: begin
        // The quadword is committed: flush has no effect, extra data is an overrun.
        if (DCU_ldDataVal) begin
          err_d = 1'b1;
        end else begin
          err_d = 1'b0;
        end
        if (APU_ldAck) begin
          state_d = ST_IDLE;
          ben_d   = {QW_BYTES{1'b0}};
          if (PCL_apuLdStart) begin
            if (start_legal_s) begin
              state_d = ST_COLLECT;
              rem_d   = start_rem_s;
              lane_d  = start_lane_s;
              data_d  = {QW_BITS{1'b0}};
            end else begin
              err_d   = 1'b1;
            end
          end else begin
            state_d = ST_IDLE;
          end
        end else if (PCL_apuLdStart) begin
          err_d = 1'b1;
        end else begin
          state_d = ST_HOLD;
        end
      end

      default: begin
        state_d = ST_IDLE;
        ben_d   = {QW_BYTES{1'b0}};
      end
    endcase

    val_d  = (state_d == ST_HOLD);
    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge CB) begin
    if (resetCore) begin
      state_q <= ST_IDLE;
      data_q  <= {QW_BITS{1'b0}};
      ben_q   <= {QW_BYTES{1'b0}};
      val_q   <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      rem_q   <= 3'd0;
      lane_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      ben_q   <= ben_d;
      val_q   <= val_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
      rem_q   <= rem_d;
      lane_q  <= lane_d;
    end
  end

  assign APU_ldData    = data_q;
  assign APU_ldDataVal = val_q;
  assign APU_ldByteEn  = ben_q;
  assign asmBusy       = busy_q;
  assign asmErr        = err_q;

endmodule
